// File: rtl/pc_pkg.sv
// Shared types for the PC sequencer: FSM states and the next-PC priority select.
package pc_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    RET_LOAD = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    SEL_INT    = 3'd0,
    SEL_CALL   = 3'd1,
    SEL_RET    = 3'd2,
    SEL_BRANCH = 3'd3,
    SEL_STALL  = 3'd4,
    SEL_INC    = 3'd5
  } sel_e;

  function automatic sel_e pick_sel(input logic int_v, input logic call_v,
                                    input logic ret_v, input logic branch_v,
                                    input logic stall_v);
    sel_e sel;
    if (int_v)         sel = SEL_INT;
    else if (call_v)   sel = SEL_CALL;
    else if (ret_v)    sel = SEL_RET;
    else if (branch_v) sel = SEL_BRANCH;
    else if (stall_v)  sel = SEL_STALL;
    else               sel = SEL_INC;
    return sel;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic            empty,
  output logic            full,
  output logic [PC_W-1:0] top
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  logic [PC_W-1:0]  r_mem [DEPTH];
  logic [IDX_W-1:0] r_top;
  logic [IDX_W:0]   r_cnt;
  logic [IDX_W-1:0] w_nxt;
  logic [IDX_W-1:0] w_prv;

  assign w_nxt = (r_top == LAST) ? IDX_W'(0) : r_top + IDX_W'(1);
  assign w_prv = (r_top == IDX_W'(0)) ? LAST : r_top - IDX_W'(1);
  assign empty = (r_cnt == (IDX_W+1)'(0));
  assign full  = (r_cnt == (IDX_W+1)'(DEPTH));
  assign top   = r_mem[r_top];

  // Stack pointer and entry count move on the same falling edge as the PC
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_top <= LAST;
      r_cnt <= (IDX_W+1)'(0);
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (push) begin
      r_top        <= w_nxt;
      r_mem[w_nxt] <= push_data;
      if (!full) r_cnt <= r_cnt + (IDX_W+1)'(1);
      else       r_cnt <= r_cnt;
    end else if (pop && !empty) begin
      r_top <= w_prv;
      r_cnt <= r_cnt - (IDX_W+1)'(1);
    end else begin
      r_top <= r_top;
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with multi-beat memory return path.
// Optional return-address stack is enabled by defining PC_RAS_EN.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int PC_W      = 32,
  parameter int DATA_W    = 16,
  parameter int RESET_VEC = 32,
  parameter int INT_VEC   = 0,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_valid,
  input  logic [PC_W-1:0]   branch_addr,
  input  logic              call_valid,
  input  logic [PC_W-1:0]   call_addr,
  input  logic              int_valid,
  input  logic              ret_valid,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_data,
  output logic [PC_W-1:0]   pc,
  output logic              ret_busy,
  output logic              ret_done
);
  localparam int BEATS = PC_W / DATA_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_e           r_state;
  logic [PC_W-1:0]  r_pc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  sel_e             w_sel;

  assign w_sel = pick_sel(int_valid, call_valid, ret_valid, branch_valid, stall);

`ifdef PC_RAS_EN
  logic            w_ras_empty;
  logic            w_ras_full;
  logic [PC_W-1:0] w_ras_top;
  logic            w_push;
  logic            w_pop;

  assign w_push = (r_state == RUN) && (w_sel == SEL_CALL);
  assign w_pop  = (r_state == RUN) && (w_sel == SEL_RET) && !w_ras_empty;

  pc_ras #(.PC_W(PC_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (r_pc + PC_W'(1)),
    .empty     (w_ras_empty),
    .full      (w_ras_full),
    .top       (w_ras_top)
  );
`endif

  // Sequencer state; everything advances on the falling clock edge
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
      r_pc    <= PC_W'(RESET_VEC);
      r_cnt   <= CNT_W'(0);
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        RUN: begin
          case (w_sel)
            SEL_INT:    r_pc <= PC_W'(INT_VEC);
            SEL_CALL:   r_pc <= call_addr;
            SEL_RET: begin
`ifdef PC_RAS_EN
              if (!w_ras_empty) begin
                r_pc   <= w_ras_top;
                r_done <= 1'b1;
              end else begin
                r_state <= RET_LOAD;
                r_busy  <= 1'b1;
                r_cnt   <= CNT_W'(BEATS - 1);
              end
`else
              r_state <= RET_LOAD;
              r_busy  <= 1'b1;
              r_cnt   <= CNT_W'(BEATS - 1);
`endif
            end
            SEL_BRANCH: r_pc <= branch_addr;
            SEL_STALL:  r_pc <= r_pc;
            SEL_INC:    r_pc <= r_pc + PC_W'(1);
            default:    r_pc <= r_pc;
          endcase
        end
        RET_LOAD: begin
          // An interrupt abandons a partly loaded return address
          if (int_valid) begin
            r_pc    <= PC_W'(INT_VEC);
            r_state <= RUN;
            r_busy  <= 1'b0;
            r_cnt   <= CNT_W'(0);
          end else if (mem_valid) begin
            r_pc[r_cnt*DATA_W +: DATA_W] <= mem_data;
            if (r_cnt == CNT_W'(0)) begin
              r_state <= RUN;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end else begin
            r_pc  <= r_pc;
            r_cnt <= r_cnt;
          end
        end
        default: begin
          r_state <= RUN;
          r_busy  <= 1'b0;
          r_cnt   <= CNT_W'(0);
        end
      endcase
    end
  end

  assign pc       = r_pc;
  assign ret_busy = r_busy;
  assign ret_done = r_done;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected pc/ret_busy/ret_done queued per cycle.
module tb_pc_sequencer;

  typedef struct packed {
    logic [5:0]  ev;   // {int, call, ret, branch, stall, mem}
    logic [31:0] addr;
    logic [15:0] md;
    logic [31:0] pc;
    logic        busy;
    logic        done;
  } stp_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        busy;
    logic        done;
  } exp_t;

  localparam logic [5:0] E_NONE = 6'b000000;
  localparam logic [5:0] E_INT  = 6'b100000;
  localparam logic [5:0] E_CALL = 6'b010000;
  localparam logic [5:0] E_RET  = 6'b001000;
  localparam logic [5:0] E_BR   = 6'b000100;
  localparam logic [5:0] E_ST   = 6'b000010;
  localparam logic [5:0] E_MEM  = 6'b000001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0, branch_valid = 1'b0, call_valid = 1'b0;
  logic        int_valid = 1'b0, ret_valid = 1'b0, mem_valid = 1'b0;
  logic [31:0] branch_addr = 32'd0, call_addr = 32'd0;
  logic [15:0] mem_data = 16'd0;
  logic [31:0] pc;
  logic        ret_busy, ret_done;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_valid(branch_valid),
    .branch_addr(branch_addr), .call_valid(call_valid), .call_addr(call_addr),
    .int_valid(int_valid), .ret_valid(ret_valid), .mem_valid(mem_valid),
    .mem_data(mem_data), .pc(pc), .ret_busy(ret_busy), .ret_done(ret_done)
  );

  always #5 clk = ~clk;

  function automatic stp_t mk(input logic [5:0] ev, input logic [31:0] addr,
                              input logic [15:0] md, input logic [31:0] epc,
                              input logic ebusy, input logic edone);
    stp_t s;
    s.ev = ev; s.addr = addr; s.md = md; s.pc = epc; s.busy = ebusy; s.done = edone;
    return s;
  endfunction

  task automatic apply(input stp_t s);
    int_valid    = s.ev[5];
    call_valid   = s.ev[4];
    ret_valid    = s.ev[3];
    branch_valid = s.ev[2];
    stall        = s.ev[1];
    mem_valid    = s.ev[0];
    call_addr    = s.addr;
    branch_addr  = s.addr;
    mem_data     = s.md;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b0;
    #2;
    sb.push_back('{pc: 32'd32, busy: 1'b0, done: 1'b0});
    e = sb.pop_front();
    n_checks++;
    if (pc !== e.pc || ret_busy !== e.busy || ret_done !== e.done) begin
      n_fail++;
      $display("FAIL reset_low: got pc=%h busy=%b done=%b, want pc=%h busy=%b done=%b",
               pc, ret_busy, ret_done, e.pc, e.busy, e.done);
    end
    reset = 1'b1;
    #1;
    sb.push_back('{pc: 32'd32, busy: 1'b0, done: 1'b0});
    e = sb.pop_front();
    n_checks++;
    if (pc !== e.pc || ret_busy !== e.busy || ret_done !== e.done) begin
      n_fail++;
      $display("FAIL reset_release: got pc=%h busy=%b done=%b, want pc=%h busy=%b done=%b",
               pc, ret_busy, ret_done, e.pc, e.busy, e.done);
    end
    for (int k = 1; k <= 3; k++) begin
      sb.push_back('{pc: 32'(32 + k), busy: 1'b0, done: 1'b0});
      tick();
      e = sb.pop_front();
      n_checks++;
      if (pc !== e.pc || ret_busy !== e.busy || ret_done !== e.done) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: got pc=%h busy=%b done=%b, want pc=%h busy=%b done=%b",
                 k, pc, ret_busy, ret_done, e.pc, e.busy, e.done);
      end
    end
  endtask

  task automatic test_ret_load();
    stp_t s[$];
    exp_t e;
    s.push_back(mk(E_BR,               32'd40, 16'h0000, 32'd40,        1'b0, 1'b0));
    s.push_back(mk(E_RET,              32'd0,  16'h0000, 32'd40,        1'b1, 1'b0));
    s.push_back(mk(E_MEM,              32'd0,  16'h0001, 32'h0001_0028, 1'b1, 1'b0));
    s.push_back(mk(E_ST | E_BR | E_CALL, 32'd9, 16'hFFFF, 32'h0001_0028, 1'b1, 1'b0));
    s.push_back(mk(E_MEM,              32'd0,  16'h2345, 32'h0001_2345, 1'b0, 1'b1));
    s.push_back(mk(E_NONE,             32'd0,  16'h0000, 32'h0001_2346, 1'b0, 1'b0));
    foreach (s[k]) begin
      apply(s[k]);
      sb.push_back('{pc: s[k].pc, busy: s[k].busy, done: s[k].done});
      tick();
      e = sb.pop_front();
      n_checks++;
      if (pc !== e.pc || ret_busy !== e.busy || ret_done !== e.done) begin
        n_fail++;
        $display("FAIL ret_load[%0d]: got pc=%h busy=%b done=%b, want pc=%h busy=%b done=%b",
                 k, pc, ret_busy, ret_done, e.pc, e.busy, e.done);
      end
    end
    apply(mk(E_NONE, 32'd0, 16'h0, 32'd0, 1'b0, 1'b0));
  endtask

  task automatic test_int_priority();
    stp_t s[$];
    exp_t e;
    s.push_back(mk(E_INT | E_CALL, 32'd100, 16'h0000, 32'd0,         1'b0, 1'b0));
    s.push_back(mk(E_RET,          32'd0,   16'h0000, 32'd0,         1'b1, 1'b0));
    s.push_back(mk(E_MEM,          32'd0,   16'hABCD, 32'hABCD_0000, 1'b1, 1'b0));
    s.push_back(mk(E_INT | E_MEM,  32'd0,   16'h1111, 32'd0,         1'b0, 1'b0));
    s.push_back(mk(E_NONE,         32'd0,   16'h0000, 32'd1,         1'b0, 1'b0));
    foreach (s[k]) begin
      apply(s[k]);
      sb.push_back('{pc: s[k].pc, busy: s[k].busy, done: s[k].done});
      tick();
      e = sb.pop_front();
      n_checks++;
      if (pc !== e.pc || ret_busy !== e.busy || ret_done !== e.done) begin
        n_fail++;
        $display("FAIL int_priority[%0d]: got pc=%h busy=%b done=%b, want pc=%h busy=%b done=%b",
                 k, pc, ret_busy, ret_done, e.pc, e.busy, e.done);
      end
    end
    apply(mk(E_NONE, 32'd0, 16'h0, 32'd0, 1'b0, 1'b0));
  endtask

  task automatic test_wrap_branch();
    stp_t s[$];
    exp_t e;
    s.push_back(mk(E_BR,                 32'hFFFF_FFFF, 16'h0000, 32'hFFFF_FFFF, 1'b0, 1'b0));
    s.push_back(mk(E_NONE,               32'd0,  16'h0000, 32'd0,  1'b0, 1'b0));
    s.push_back(mk(E_ST | E_BR,          32'd50, 16'h0000, 32'd50, 1'b0, 1'b0));
    s.push_back(mk(E_ST,                 32'd0,  16'h0000, 32'd50, 1'b0, 1'b0));
    s.push_back(mk(E_RET | E_BR,         32'd9,  16'h0000, 32'd50, 1'b1, 1'b0));
    s.push_back(mk(E_ST | E_BR | E_CALL, 32'd7,  16'h0000, 32'd50, 1'b1, 1'b0));
    s.push_back(mk(E_MEM,                32'd0,  16'h0000, 32'd50, 1'b1, 1'b0));
    s.push_back(mk(E_MEM,                32'd0,  16'h0005, 32'd5,  1'b0, 1'b1));
    s.push_back(mk(E_CALL | E_RET,       32'd77, 16'h0000, 32'd77, 1'b0, 1'b0));
    foreach (s[k]) begin
      apply(s[k]);
      sb.push_back('{pc: s[k].pc, busy: s[k].busy, done: s[k].done});
      tick();
      e = sb.pop_front();
      n_checks++;
      if (pc !== e.pc || ret_busy !== e.busy || ret_done !== e.done) begin
        n_fail++;
        $display("FAIL wrap_branch[%0d]: got pc=%h busy=%b done=%b, want pc=%h busy=%b done=%b",
                 k, pc, ret_busy, ret_done, e.pc, e.busy, e.done);
      end
    end
    apply(mk(E_NONE, 32'd0, 16'h0, 32'd0, 1'b0, 1'b0));
  endtask

  task automatic test_reset_mid();
    stp_t s[$];
    exp_t e;
    s.push_back(mk(E_BR,  32'd40, 16'h0000, 32'd40,        1'b0, 1'b0));
    s.push_back(mk(E_RET, 32'd0,  16'h0000, 32'd40,        1'b1, 1'b0));
    s.push_back(mk(E_MEM, 32'd0,  16'h7777, 32'h7777_0028, 1'b1, 1'b0));
    foreach (s[k]) begin
      apply(s[k]);
      sb.push_back('{pc: s[k].pc, busy: s[k].busy, done: s[k].done});
      tick();
      e = sb.pop_front();
      n_checks++;
      if (pc !== e.pc || ret_busy !== e.busy || ret_done !== e.done) begin
        n_fail++;
        $display("FAIL reset_mid[%0d]: got pc=%h busy=%b done=%b, want pc=%h busy=%b done=%b",
                 k, pc, ret_busy, ret_done, e.pc, e.busy, e.done);
      end
    end
    apply(mk(E_NONE, 32'd0, 16'h0, 32'd0, 1'b0, 1'b0));
    reset = 1'b0;
    #2;
    sb.push_back('{pc: 32'd32, busy: 1'b0, done: 1'b0});
    e = sb.pop_front();
    n_checks++;
    if (pc !== e.pc || ret_busy !== e.busy || ret_done !== e.done) begin
      n_fail++;
      $display("FAIL reset_mid_async: got pc=%h busy=%b done=%b, want pc=%h busy=%b done=%b",
               pc, ret_busy, ret_done, e.pc, e.busy, e.done);
    end
    reset = 1'b1;
    sb.push_back('{pc: 32'd33, busy: 1'b0, done: 1'b0});
    tick();
    e = sb.pop_front();
    n_checks++;
    if (pc !== e.pc || ret_busy !== e.busy || ret_done !== e.done) begin
      n_fail++;
      $display("FAIL reset_mid_after: got pc=%h busy=%b done=%b, want pc=%h busy=%b done=%b",
               pc, ret_busy, ret_done, e.pc, e.busy, e.done);
    end
  endtask

`ifdef PC_RAS_EN
  task automatic test_ras();
    stp_t s[$];
    exp_t e;
    s.push_back(mk(E_BR,   32'd10,   16'h0000, 32'd10,   1'b0, 1'b0));
    s.push_back(mk(E_CALL, 32'd200,  16'h0000, 32'd200,  1'b0, 1'b0));
    s.push_back(mk(E_RET,  32'd0,    16'h0000, 32'd11,   1'b0, 1'b1));
    s.push_back(mk(E_CALL, 32'd1000, 16'h0000, 32'd1000, 1'b0, 1'b0));
    s.push_back(mk(E_CALL, 32'd2000, 16'h0000, 32'd2000, 1'b0, 1'b0));
    s.push_back(mk(E_CALL, 32'd3000, 16'h0000, 32'd3000, 1'b0, 1'b0));
    s.push_back(mk(E_CALL, 32'd4000, 16'h0000, 32'd4000, 1'b0, 1'b0));
    s.push_back(mk(E_CALL, 32'd5000, 16'h0000, 32'd5000, 1'b0, 1'b0));
    s.push_back(mk(E_RET,  32'd0,    16'h0000, 32'd4001, 1'b0, 1'b1));
    s.push_back(mk(E_RET,  32'd0,    16'h0000, 32'd3001, 1'b0, 1'b1));
    s.push_back(mk(E_RET,  32'd0,    16'h0000, 32'd2001, 1'b0, 1'b1));
    s.push_back(mk(E_RET,  32'd0,    16'h0000, 32'd1001, 1'b0, 1'b1));
    s.push_back(mk(E_RET,  32'd0,    16'h0000, 32'd1001, 1'b1, 1'b0));
    s.push_back(mk(E_MEM,  32'd0,    16'h0000, 32'd1001, 1'b1, 1'b0));
    s.push_back(mk(E_MEM,  32'd0,    16'h0063, 32'h63,   1'b0, 1'b1));
    foreach (s[k]) begin
      apply(s[k]);
      sb.push_back('{pc: s[k].pc, busy: s[k].busy, done: s[k].done});
      tick();
      e = sb.pop_front();
      n_checks++;
      if (pc !== e.pc || ret_busy !== e.busy || ret_done !== e.done) begin
        n_fail++;
        $display("FAIL ras[%0d]: got pc=%h busy=%b done=%b, want pc=%h busy=%b done=%b",
                 k, pc, ret_busy, ret_done, e.pc, e.busy, e.done);
      end
    end
    apply(mk(E_NONE, 32'd0, 16'h0, 32'd0, 1'b0, 1'b0));
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_ret_load();
    test_int_priority();
    test_wrap_branch();
    test_reset_mid();
`ifdef PC_RAS_EN
    test_ras();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 32, program-counter width; must be an integer multiple of DATA_W.
REQ-002 SHALL have parameter DATA_W, default 16, width of the memory return-data word.
REQ-003 SHALL have parameter RESET_VEC, default 32, PC value loaded on reset.
REQ-004 SHALL have parameter INT_VEC, default 0, interrupt-handler entry address.
REQ-005 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries; used only with PC_RAS_EN.
REQ-006 SHALL have ports: clk in 1, the single clock; reset in 1, asynchronous, active-low.
REQ-007 SHALL have ports: stall in 1 (hold PC); branch_valid in 1; branch_addr in PC_W.
REQ-008 SHALL have ports: call_valid in 1; call_addr in PC_W; int_valid in 1; ret_valid in 1.
REQ-009 SHALL have ports: mem_valid in 1 (one return-address beat present); mem_data in DATA_W.
REQ-010 SHALL have ports: pc out PC_W; ret_busy out 1 (multi-beat return in progress); ret_done out 1 (one-cycle pulse on completion).

Function
REQ-011 SHALL update all state on the falling edge of clk.
REQ-012 SHALL implement FSM states RUN and RET_LOAD; BEATS = PC_W/DATA_W.
REQ-013 SHALL in RUN apply priority int_valid > call_valid > ret_valid > branch_valid > stall > increment.
REQ-014 SHALL on int_valid load pc = INT_VEC.
REQ-015 SHALL on call_valid load pc = call_addr.
REQ-016 SHALL on ret_valid (memory path) enter RET_LOAD with beat counter = BEATS-1 and hold pc.
REQ-017 SHALL on branch_valid load pc = branch_addr; on stall hold pc; otherwise pc = pc+1, wrapping modulo 2^PC_W.
REQ-018 SHALL in RET_LOAD, per cycle with mem_valid, write mem_data into pc slice [cnt*DATA_W +: DATA_W] (most-significant beat first) and decrement cnt.
REQ-019 SHALL in RET_LOAD, when mem_valid is low, hold pc and cnt regardless of stall.
REQ-020 SHALL on the beat with cnt = 0 return to RUN and pulse ret_done for exactly one cycle.
REQ-021 SHALL in RET_LOAD give int_valid precedence: abort the load, pc = INT_VEC, state RUN, no ret_done.
REQ-022 SHALL ignore call_valid, ret_valid, branch_valid and stall while in RET_LOAD.
REQ-023 SHALL drive ret_busy = 1 exactly when state = RET_LOAD.
REQ-024 SHALL treat the case BEATS = 1 as completing on the first mem_valid cycle.

Reset
REQ-025 SHALL on reset low immediately set pc = RESET_VEC, state RUN, cnt 0, ret_busy 0, ret_done 0, including mid-RET_LOAD.
REQ-026 SHALL with PC_RAS_EN clear the stack pointer to empty on reset.

Configuration
REQ-027 SHALL honour macro PC_RAS_EN.
REQ-028 SHALL with PC_RAS_EN defined push pc+1 onto a RAS_DEPTH-entry stack on call_valid, overwriting the oldest entry when full.
REQ-029 SHALL with PC_RAS_EN defined, on ret_valid with a non-empty stack, pop into pc in one cycle, pulse ret_done, and not enter RET_LOAD.
REQ-030 SHALL with PC_RAS_EN defined, on ret_valid with an empty stack, fall back to the RET_LOAD memory path.
REQ-031 SHALL with PC_RAS_EN undefined contain no stack logic and always use RET_LOAD for returns.

Structure
REQ-032 SHALL place the state enum (RUN, RET_LOAD) and the priority-select encoding in shared package pc_pkg.
REQ-033 SHALL implement the stack as sub-module pc_ras (push, pop, empty, full, top), instantiated only under PC_RAS_EN.

Verification
REQ-034 SHALL cover: reset low then high, 3 idle cycles -> pc 32, 33, 34, 35.
REQ-035 SHALL cover: pc=40, ret_valid, then beats 0x0001 and 0x2345 with a one-cycle mem_valid gap between them -> pc 0x00012345; ret_busy for 3 cycles; single ret_done.
REQ-036 SHALL cover: int_valid and call_valid (call_addr 100) in the same cycle -> pc 0; then in RET_LOAD after one beat, int_valid -> pc 0, ret_busy 0, no ret_done.
REQ-037 SHALL cover: pc=0xFFFFFFFF, no events -> pc 0; stall with branch_valid (addr 50) -> pc 50.
REQ-038 SHALL cover (PC_RAS_EN): at pc=10 call to 200, then ret_valid -> pc 11 the next cycle with no RET_LOAD; five nested calls with RAS_DEPTH=4 then five returns -> 5th return uses memory path.
